// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint controller that gates a processor clock enable.
// Ports:
//   Clk, Reset       - system clock, synchronous active-low reset
//   RunSw, StepBtn   - asynchronous run switch and bouncy single-step button
//   BrkEn, BrkAddr   - breakpoint enable and breakpoint PC
//   PCResult         - current processor PC
//   CpuEn            - one-cycle processor advance pulse
//   State, Halted    - controller state (0 HALT, 1 RUN, 2 STEP, 3 BREAK) and halted flag
//   CycleCount       - saturating count of CpuEn pulses
module cpu_run_ctrl #(
    parameter int unsigned DIV_MAX    = 4,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RunSw,
    input  logic        StepBtn,
    input  logic        BrkEn,
    input  logic [31:0] BrkAddr,
    input  logic [31:0] PCResult,
    output logic        CpuEn,
    output logic [1:0]  State,
    output logic        Halted,
    output logic [31:0] CycleCount
);

    localparam int unsigned DIV_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_e;

    state_e             state_q;
    state_e             state_nxt;
    logic [DIV_W-1:0]   div_q;
    logic               tick;
    logic               run_meta;
    logic               run_s;
    logic               step_meta;
    logic               step_s;
    logic [DEB_W-1:0]   deb_cnt;
    logic               deb_level;
    logic               deb_prev;
    logic               step_req;
    logic               skip_q;
    logic               brk_hit;
    logic               cpu_en_nxt;
    logic               halted_nxt;
    logic               skip_nxt;
    logic [31:0]        cycle_nxt;

    // Free-running processor tick divider
    assign tick = (div_q == DIV_W'(DIV_MAX - 1));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Two-flop synchronizers for the asynchronous switch and button
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            run_meta  <= 1'b0;
            run_s     <= 1'b0;
            step_meta <= 1'b0;
            step_s    <= 1'b0;
        end else begin
            run_meta  <= RunSw;
            run_s     <= run_meta;
            step_meta <= StepBtn;
            step_s    <= step_meta;
        end
    end

    // Debounce: level follows step_s only after DEB_CYCLES consecutive differing samples;
    // step_req is a registered one-cycle pulse on the debounced rising edge.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            step_req  <= 1'b0;
        end else begin
            if (step_s != deb_level) begin
                if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_level <= step_s;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt   <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
            deb_prev <= deb_level;
            step_req <= deb_level & ~deb_prev;
        end
    end

    // Breakpoint is suppressed until the first tick after entering RUN
    assign brk_hit = BrkEn && !skip_q && (PCResult == BrkAddr);

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_HALT;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; STEP leaves only once its pulse is on CpuEn so the pulse
    // never overlaps HALT or BREAK.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_HALT: begin
                if (run_s) begin
                    state_nxt = ST_RUN;
                end else if (step_req) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!run_s) begin
                    state_nxt = ST_HALT;
                end else if (tick && brk_hit) begin
                    state_nxt = ST_BREAK;
                end
            end
            ST_STEP: begin
                if (CpuEn) begin
                    state_nxt = run_s ? ST_BREAK : ST_HALT;
                end
            end
            ST_BREAK: begin
                if (!run_s) begin
                    state_nxt = ST_HALT;
                end else if (step_req) begin
                    state_nxt = ST_STEP;
                end
            end
            default: state_nxt = ST_HALT;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        cpu_en_nxt = 1'b0;
        skip_nxt   = skip_q;
        cycle_nxt  = CycleCount;
        halted_nxt = (state_nxt == ST_HALT) || (state_nxt == ST_BREAK);

        case (state_q)
            ST_RUN:  cpu_en_nxt = run_s && tick && !brk_hit;
            ST_STEP: cpu_en_nxt = !CpuEn && tick;
            default: cpu_en_nxt = 1'b0;
        endcase

        if ((state_q != ST_RUN) && (state_nxt == ST_RUN)) begin
            skip_nxt = 1'b1;
        end else if ((state_q == ST_RUN) && tick) begin
            skip_nxt = 1'b0;
        end

        if (CpuEn && (CycleCount != 32'hFFFF_FFFF)) begin
            cycle_nxt = CycleCount + 32'd1;
        end
    end

    // Output registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            CpuEn      <= 1'b0;
            Halted     <= 1'b1;
            skip_q     <= 1'b1;
            CycleCount <= '0;
        end else begin
            CpuEn      <= cpu_en_nxt;
            Halted     <= halted_nxt;
            skip_q     <= skip_nxt;
            CycleCount <= cycle_nxt;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: reset/run vector table, directed breakpoint, step,
// bounce, saturation and reset-in-STEP sequences, then random stimulus against a
// behavioural model.
module tb_cpu_run_ctrl;

    localparam int unsigned DIV_MAX    = 4;
    localparam int unsigned DEB_CYCLES = 4;
    localparam int M_HALT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_BREAK = 3;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        RunSw;
    logic        StepBtn;
    logic        BrkEn;
    logic [31:0] BrkAddr;
    logic [31:0] PCResult;
    logic        CpuEn;
    logic [1:0]  State;
    logic        Halted;
    logic [31:0] CycleCount;

    cpu_run_ctrl #(.DIV_MAX(DIV_MAX), .DEB_CYCLES(DEB_CYCLES)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .RunSw      (RunSw),
        .StepBtn    (StepBtn),
        .BrkEn      (BrkEn),
        .BrkAddr    (BrkAddr),
        .PCResult   (PCResult),
        .CpuEn      (CpuEn),
        .State      (State),
        .Halted     (Halted),
        .CycleCount (CycleCount)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Divider phase is the number of non-reset edges modulo DIV_MAX; the
    // synchronizers are two-entry delay lines; the debounce level flips when the
    // last DEB_CYCLES synchronized samples all disagree with it.
    int          m_cyc;
    logic        m_run_h [2];
    logic        m_step_h[2];
    logic        win[$];
    logic        m_lvl, m_lvl_prev, m_req;
    int          m_st;
    logic        m_cpu;
    logic        m_skip;
    logic [31:0] m_cnt;
    logic        force_on = 1'b0;
    logic [31:0] force_val = '0;

    always @(posedge Clk) begin : model
        logic tick, run_s, step_s, hit, all_diff, ncpu;
        int   nst;
        if (!Reset) begin
            m_cyc = 0;
            m_run_h[0] = 1'b0;  m_run_h[1] = 1'b0;
            m_step_h[0] = 1'b0; m_step_h[1] = 1'b0;
            win.delete();
            m_lvl = 1'b0; m_lvl_prev = 1'b0; m_req = 1'b0;
            m_st = M_HALT; m_cpu = 1'b0; m_skip = 1'b1; m_cnt = '0;
        end else begin
            tick   = (m_cyc % DIV_MAX) == (DIV_MAX - 1);
            run_s  = m_run_h[1];
            step_s = m_step_h[1];
            hit    = BrkEn && !m_skip && (PCResult == BrkAddr);
            nst    = m_st;
            ncpu   = 1'b0;
            case (m_st)
                M_HALT:  if (run_s) nst = M_RUN; else if (m_req) nst = M_STEP;
                M_RUN:   if (!run_s) nst = M_HALT;
                         else if (tick) begin
                             if (hit) nst = M_BREAK; else ncpu = 1'b1;
                         end
                M_STEP:  if (m_cpu) nst = run_s ? M_BREAK : M_HALT;
                         else if (tick) ncpu = 1'b1;
                default: if (!run_s) nst = M_HALT; else if (m_req) nst = M_STEP;
            endcase
            if (m_st != M_RUN && nst == M_RUN) m_skip = 1'b1;
            else if (m_st == M_RUN && tick)    m_skip = 1'b0;
            if (force_on)                                m_cnt = force_val;
            else if (m_cpu && m_cnt != 32'hFFFF_FFFF)    m_cnt = m_cnt + 1;
            m_req      = m_lvl & ~m_lvl_prev;
            m_lvl_prev = m_lvl;
            win.push_back(step_s);
            if (win.size() > DEB_CYCLES) void'(win.pop_front());
            all_diff = (win.size() == DEB_CYCLES);
            foreach (win[j]) if (win[j] == m_lvl) all_diff = 1'b0;
            if (all_diff) m_lvl = ~m_lvl;
            m_run_h[1]  = m_run_h[0];  m_run_h[0]  = RunSw;
            m_step_h[1] = m_step_h[0]; m_step_h[0] = StepBtn;
            m_st  = nst;
            m_cpu = ncpu;
            m_cyc++;
        end
    end

    logic chk_en = 1'b0;

    always @(negedge Clk) begin
        if (chk_en) begin
            check("mdl_state",  32'(State),  32'(m_st));
            check("mdl_halted", 32'(Halted), 32'((m_st == M_HALT) || (m_st == M_BREAK)));
            check("mdl_cpuen",  32'(CpuEn),  32'(m_cpu));
            check("mdl_count",  CycleCount,  m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    logic pc_auto = 1'b0;

    // Advance n cycles; the surrounding "processor" steps its PC on each CpuEn.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge Clk);
            if (pc_auto && CpuEn) PCResult = PCResult + 32'd4;
        end
    endtask

    typedef struct {
        logic        rst;
        logic        run;
        logic [1:0]  st;
        logic        hlt;
        logic        en;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[24];

    initial begin : stim
        int   n_en;
        logic saw_step;
        logic found;
        logic step_tgt;

        // Reset for 3 edges, then run: RUN two edges after RunSw is sampled,
        // CpuEn every DIV_MAX cycles from the first tick.
        for (int i = 0; i < 24; i++) begin
            tbl[i].rst = (i >= 3);
            tbl[i].run = (i >= 3);
            tbl[i].st  = (i >= 5) ? 2'd1 : 2'd0;
            tbl[i].hlt = (i < 5);
            tbl[i].en  = (i >= 6) && (((i - 6) % 4) == 0);
            tbl[i].cnt = (i >= 7) ? 32'((i - 7) / 4 + 1) : 32'd0;
        end

        Reset = 1'b0; RunSw = 1'b0; StepBtn = 1'b0; BrkEn = 1'b0;
        BrkAddr = '0; PCResult = '0;

        for (int i = 0; i < 24; i++) begin
            Reset = tbl[i].rst;
            RunSw = tbl[i].run;
            @(posedge Clk);
            #1;
            check("tbl_state",  32'(State),  32'(tbl[i].st));
            check("tbl_halted", 32'(Halted), 32'(tbl[i].hlt));
            check("tbl_cpuen",  32'(CpuEn),  32'(tbl[i].en));
            check("tbl_count",  CycleCount,  tbl[i].cnt);
            if (i == 0) chk_en = 1'b1;
            @(negedge Clk);
        end

        // Breakpoint: PC 0x0C runs, PC 0x10 breaks at its tick
        BrkEn = 1'b1; BrkAddr = 32'h10; PCResult = 32'h0C; pc_auto = 1'b1;
        for (int k = 0; k < 40 && State != 2'd3; k++) cyc(1);
        check("brk_state",  32'(State),  32'd3);
        check("brk_cpuen",  32'(CpuEn),  32'd0);
        check("brk_halted", 32'(Halted), 32'd1);
        check("brk_count",  CycleCount,  32'd6);
        n_en = 0;
        repeat (8) begin cyc(1); if (CpuEn) n_en++; end
        check("brk_no_en",  32'(n_en),   32'd0);
        check("brk_frozen", CycleCount,  32'd6);

        // Clean step press from BREAK
        StepBtn = 1'b1; n_en = 0; saw_step = 1'b0;
        repeat (20) begin
            cyc(1);
            if (CpuEn) n_en++;
            if (State == 2'd2) saw_step = 1'b1;
        end
        check("stepb_pulses", 32'(n_en),     32'd1);
        check("stepb_saw",    32'(saw_step), 32'd1);
        check("stepb_state",  32'(State),    32'd3);
        check("stepb_count",  CycleCount,    32'd7);
        StepBtn = 1'b0;
        cyc(10);
        check("stepb_release", 32'(State), 32'd3);

        // Bouncy press from HALT
        RunSw = 1'b0;
        cyc(4);
        check("halt_entry", 32'(State), 32'd0);
        n_en = 0;
        for (int t = 0; t < 10; t++) begin
            StepBtn = ~StepBtn;
            repeat (2) begin cyc(1); if (CpuEn) n_en++; end
        end
        check("bounce_no_en", 32'(n_en), 32'd0);
        StepBtn = 1'b1;
        repeat (25) begin cyc(1); if (CpuEn) n_en++; end
        check("bounce_pulses", 32'(n_en),  32'd1);
        check("bounce_state",  32'(State), 32'd0);
        check("bounce_count",  CycleCount, 32'd8);
        StepBtn = 1'b0;
        cyc(10);

        // Saturation near the top of the counter
        RunSw = 1'b1; BrkEn = 1'b0;
        cyc(4);
        check("sat_run", 32'(State), 32'd1);
        for (int k = 0; k < 8 && CpuEn; k++) cyc(1);
        chk_en = 1'b0;
        force dut.CycleCount = 32'hFFFF_FFFD;
        force_val = 32'hFFFF_FFFD;
        force_on  = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        release dut.CycleCount;
        force_on = 1'b0;
        chk_en   = 1'b1;
        n_en = 0;
        repeat (24) begin cyc(1); if (CpuEn) n_en++; end
        check("sat_count",   CycleCount,          32'hFFFF_FFFF);
        check("sat_en_cont", 32'(n_en >= 5),      32'd1);

        // Reset asserted in STEP one cycle before its tick
        RunSw = 1'b0;
        cyc(4);
        check("pre_step_halt", 32'(State), 32'd0);
        for (int k = 0; k < 8 && (m_cyc % DIV_MAX) != 0; k++) cyc(1);
        StepBtn = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            cyc(1);
            if (State == 2'd2 && (m_cyc % DIV_MAX) == (DIV_MAX - 2)) found = 1'b1;
        end
        check("rst_step_found", 32'(found), 32'd1);
        Reset = 1'b0;
        n_en = 0;
        repeat (3) begin
            cyc(1);
            if (CpuEn) n_en++;
            check("rst_state",  32'(State),  32'd0);
            check("rst_halted", 32'(Halted), 32'd1);
            check("rst_count",  CycleCount,  32'd0);
        end
        check("rst_no_en", 32'(n_en), 32'd0);
        Reset = 1'b1; StepBtn = 1'b0;
        cyc(10);

        // Random stimulus against the model
        step_tgt = 1'b0;
        for (int r = 0; r < 1500; r++) begin
            if ($urandom_range(0, 59) == 0) RunSw = ~RunSw;
            if ($urandom_range(0, 29) == 0) step_tgt = ~step_tgt;
            StepBtn = ($urandom_range(0, 7) == 0) ? ~step_tgt : step_tgt;
            if ($urandom_range(0, 99) == 0) BrkEn = ~BrkEn;
            if ($urandom_range(0, 39) == 0) BrkAddr = PCResult + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) PCResult = 32'(4 * $urandom_range(0, 7));
            Reset = ($urandom_range(0, 299) != 0);
            cyc(1);
        end
        Reset = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter DIV_MAX, default 4: processor tick period in Clk cycles (≥2).
REQ-002 Parameter DEB_CYCLES, default 4: debounce stability window for StepBtn, in Clk cycles (≥1).
REQ-003 Clk  in  1  single system clock; all logic rising-edge.
REQ-004 Reset  in  1  synchronous, active-low reset.
REQ-005 RunSw  in  1  asynchronous run switch; 1 = free-run.
REQ-006 StepBtn  in  1  asynchronous single-step pushbutton, bouncy.
REQ-007 BrkEn  in  1  breakpoint enable.
REQ-008 BrkAddr  in  32  breakpoint PC.
REQ-009 PCResult  in  32  current processor PC.
REQ-010 CpuEn  out  1  one-Clk pulse; processor advances one cycle when high.
REQ-011 State  out  2  FSM state: 0 HALT, 1 RUN, 2 STEP, 3 BREAK.
REQ-012 Halted  out  1  high in HALT or BREAK.
REQ-013 CycleCount  out  32  number of CpuEn pulses issued.

Function
REQ-014 Divider counts 0..DIV_MAX-1 every Clk, wraps to 0, free-runs in all states; tick = (divider == DIV_MAX-1).
REQ-015 RunSw passes through a 2-flop synchronizer; run_s is the second-stage output.
REQ-016 StepBtn passes through a 2-flop synchronizer; debounced level updates only after the synchronized value differs from it for DEB_CYCLES consecutive cycles; any reversion restarts the window.
REQ-017 step_req is a one-cycle pulse on each 0->1 transition of the debounced level.
REQ-018 HALT: run_s=1 -> RUN; else step_req -> STEP; else stay.
REQ-019 RUN: run_s=0 -> HALT, no CpuEn that cycle; else on tick, if BrkEn=1, skip=0 and PCResult==BrkAddr -> BREAK with CpuEn=0; else CpuEn=1 on tick.
REQ-020 skip flag: set on every entry to RUN; cleared at the first tick in RUN, so the PC present at RUN entry never triggers a break.
REQ-021 STEP: on next tick, CpuEn=1 for that cycle, with no breakpoint check; then -> HALT if run_s=0, else -> BREAK.
REQ-022 BREAK: run_s=0 -> HALT; else step_req -> STEP; else stay; CpuEn=0.
REQ-023 step_req in RUN or STEP is ignored and not queued.
REQ-024 CpuEn is registered, high for exactly one Clk, and never high in HALT or BREAK.
REQ-025 CycleCount increments by 1 in the cycle after each CpuEn pulse and saturates at 0xFFFFFFFF.
REQ-026 Halted and State are registered and consistent with each other in every cycle.
REQ-027 BrkAddr/PCResult compare is full 32-bit equality, sampled only on tick.
REQ-028 Latency: RunSw change before edge k -> State changes after edge k+2.
REQ-029 Latency: StepBtn clean rise before edge k -> step_req high after edge k+2+DEB_CYCLES.

Reset
REQ-030 Reset=0 at a Clk edge forces State=HALT, Halted=1, CpuEn=0, CycleCount=0, divider=0, all synchronizer and debounce flops 0, debounce counter 0, skip=1.
REQ-031 Reset overrides every transition, including mid-STEP and an in-flight CpuEn.
REQ-032 Outputs hold reset values for every cycle that Reset=0.
REQ-033 After release, the first divider increment occurs on the first edge with Reset=1.

Verification
REQ-034 Reset low 3 cycles, then RunSw=1, BrkEn=0 -> RUN after 2 cycles, then CpuEn every 4th cycle; CycleCount=5 after 5 pulses.
REQ-035 RUN, BrkEn=1, BrkAddr=0x10, PCResult steps 0x0C->0x10 -> at the tick with PC=0x10: CpuEn=0, State=3, Halted=1, CycleCount frozen.
REQ-036 BREAK, clean StepBtn press -> exactly one CpuEn, State 2->3, CycleCount+1.
REQ-037 HALT, StepBtn toggling every 2 cycles for 20 cycles, then stable high -> exactly one CpuEn; State returns to 0.
REQ-038 RUN with CycleCount preset near 0xFFFFFFFF by forcing -> count stops at 0xFFFFFFFF, CpuEn continues.
REQ-039 Reset asserted in STEP one cycle before tick -> no CpuEn, State=0, CycleCount=0.
